regfile_dump_unit: RTL and testbench

//  Debug reader for the register_file read side. On start it walks read_reg over R0..R(NUM_REGS-1),

---
 rtl/regfile_dump_unit_pkg.sv | 27 ++
 rtl/regfile_dump_unit_if.sv | 32 +++
 rtl/regfile_dump_unit.sv | 126 ++++++++++++
 tb/tb_regfile_dump_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_unit_pkg.sv
// Shared constants and FSM state type for the register-file dump unit.
// Optional feature macro: REGFILE_DUMP_CSUM_EN (adds a trailing XOR checksum word).
package regfile_dump_unit_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   // Index of the final register walked.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CSUM_EN
   // dump_addr value that tags the checksum word (one past the last register).
   localparam logic [ADDR_W:0] CSUM_ADDR = (ADDR_W + 1)'(NUM_REGS);
`endif

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_SEND = 3'd2,
`ifdef REGFILE_DUMP_CSUM_EN
      ST_CSUM = 3'd3,
`endif
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Control, register-file read side and dump stream of the dump unit.
// Stream handshake: the master raises dump_valid with dump_addr/data/last and holds
// all of them stable until a rising edge where dump_valid & dump_ready are both 1;
// that edge transfers the word. The slave may drive dump_ready freely.
interface regfile_dump_unit_if;
   import regfile_dump_unit_pkg::*;

   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rf_read_reg;
   logic [DATA_W-1:0] rf_read_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W:0]   dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;
   state_e            dbg_state;

   // Dump unit side.
   modport master (
      input  start, rf_read_data, dump_ready,
      output busy, done, rf_read_reg, dump_valid, dump_addr, dump_data, dump_last, dbg_state
   );

   // Parent / sink side.
   modport slave (
      output start, rf_read_data, dump_ready,
      input  busy, done, rf_read_reg, dump_valid, dump_addr, dump_data, dump_last, dbg_state
   );

endinterface

// File: rtl/regfile_dump_unit.sv
// Register-file dump unit: walks R0..R(NUM_REGS-1) through an external read port
// (muxed by busy in the parent) and streams {addr,data} words on a valid/ready port.
// Optional feature macro: REGFILE_DUMP_CSUM_EN appends an XOR checksum word.
module regfile_dump_unit
   import regfile_dump_unit_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   regfile_dump_unit_if.master bus
);

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              done_q;
   logic              valid_q;
   logic              last_q;
   logic [ADDR_W:0]   addr_q;
   logic [DATA_W-1:0] data_q;
`ifdef REGFILE_DUMP_CSUM_EN
   logic [DATA_W-1:0] acc_q;
`endif

   logic              hs;

   // A word leaves the output register on this edge.
   assign hs = valid_q & bus.dump_ready;

   // Walk FSM, index counter and output register; every output is registered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
         acc_q   <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_READ;
                  idx_q   <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
                  acc_q   <= '0;
`endif
               end
            end
            // rf_read_reg already shows idx_q; capture the combinational read data.
            ST_READ: begin
               data_q  <= bus.rf_read_data;
               addr_q  <= {1'b0, idx_q};
               valid_q <= 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
               last_q  <= 1'b0;
               acc_q   <= acc_q ^ bus.rf_read_data;
`else
               last_q  <= (idx_q == LAST_IDX);
`endif
               state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (hs) begin
                  if (idx_q != LAST_IDX) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     idx_q   <= idx_q + 1'b1;
                     state_q <= ST_READ;
                  end else begin
`ifdef REGFILE_DUMP_CSUM_EN
                     // Checksum word follows directly in the output register.
                     valid_q <= 1'b1;
                     last_q  <= 1'b1;
                     addr_q  <= CSUM_ADDR;
                     data_q  <= acc_q;
                     state_q <= ST_CSUM;
`else
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
`endif
                  end
               end
            end
`ifdef REGFILE_DUMP_CSUM_EN
            ST_CSUM: begin
               if (hs) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
`endif
            // One-cycle done pulse; index returns to 0 so rf_read_reg reads 0 in IDLE.
            ST_DONE: begin
               done_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               done_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.rf_read_reg = idx_q;
   assign bus.dump_valid  = valid_q;
   assign bus.dump_addr   = addr_q;
   assign bus.dump_data   = data_q;
   assign bus.dump_last   = last_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: a small register file shares its read port with the
// unit through a busy-selected mux; a scoreboard queue holds the expected stream.
// Optional feature macro: REGFILE_DUMP_CSUM_EN (expects the trailing checksum word).
module tb_regfile_dump_unit;
   import regfile_dump_unit_pkg::*;

   localparam int WW = 1 + (ADDR_W + 1) + DATA_W;  // {last, addr, data}

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   regfile_dump_unit_if bus ();

   regfile_dump_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- register file + read-port mux ----------------
   logic [DATA_W-1:0] rf_mem [NUM_REGS];
   logic [DATA_W-1:0] shadow [NUM_REGS];
   logic              rf_we = 1'b0;
   logic [ADDR_W-1:0] rf_waddr = '0;
   logic [DATA_W-1:0] rf_wdata = '0;
   logic [ADDR_W-1:0] dp_read_reg = ADDR_W'(3);
   logic [ADDR_W-1:0] rf_raddr;

   always_ff @(posedge clock) begin
      if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
   end

   assign rf_raddr         = bus.busy ? bus.rf_read_reg : dp_read_reg;
   assign bus.rf_read_data = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

   // ---------------- bookkeeping ----------------
   int             n_checks = 0;
   int             n_fail   = 0;
   int             done_cycles = 0;
   logic [WW-1:0]  exp_q [$];
   logic [WW-1:0]  cur_w;
   logic [WW-1:0]  held_w;
   logic [WW-1:0]  exp_w;
   bit             held_v = 1'b0;
   bit             bp_stop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard / monitor (mid-cycle) ----------------
   always @(negedge clock) begin
      if (!reset) begin
         held_v = 1'b0;
      end else begin
         cur_w = {bus.dump_last, bus.dump_addr, bus.dump_data};
         if (bus.done) done_cycles++;
         if (held_v) begin
            check("hold_valid", 64'(bus.dump_valid), 64'd1);
            check("hold_word", 64'(cur_w), 64'(held_w));
         end
         if (bus.dump_valid && bus.dump_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word_queue", 64'(exp_q.size()), 64'd1);
            end else begin
               exp_w = exp_q.pop_front();
               check($sformatf("word_a%0d", exp_w[DATA_W +: ADDR_W+1]), 64'(cur_w), 64'(exp_w));
            end
         end
         held_v = bus.dump_valid && !bus.dump_ready;
         held_w = cur_w;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rf_write(input int a, input logic [DATA_W-1:0] d);
      rf_we    = 1'b1;
      rf_waddr = ADDR_W'(a);
      rf_wdata = d;
      @(posedge clock); #1;
      rf_we    = 1'b0;
      if (a != 0) shadow[a] = d;
   endtask

   task automatic push_dump();
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] d;
      logic              lst;
      x = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         d = (i == 0) ? '0 : shadow[i];
         x ^= d;
`ifdef REGFILE_DUMP_CSUM_EN
         lst = 1'b0;
`else
         lst = (i == NUM_REGS - 1);
`endif
         exp_q.push_back({lst, (ADDR_W + 1)'(i), d});
      end
`ifdef REGFILE_DUMP_CSUM_EN
      exp_q.push_back({1'b1, (ADDR_W + 1)'(NUM_REGS), x});
`endif
   endtask

   // Pulse start for one cycle (caller sits at posedge+1) and queue the expected dump.
   task automatic pulse_start();
      bus.start = 1'b1;
      push_dump();
      @(posedge clock); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      int c;
      bit seen;
      c = 0;
      seen = 1'b0;
      while (!seen && c < budget) begin
         @(posedge clock); #1;
         c++;
         if (bus.done) seen = 1'b1;
      end
      check("done_seen", 64'(seen), 64'd1);
      cycles = c;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc;
      int dc;
      int ph;
      bit found;

      bus.start      = 1'b0;
      bus.dump_ready = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] = '0;

      // 1: reset held mid-cycle
      #12;
      check("rst_busy",  64'(bus.busy), 64'd0);
      check("rst_done",  64'(bus.done), 64'd0);
      check("rst_valid", 64'(bus.dump_valid), 64'd0);
      check("rst_last",  64'(bus.dump_last), 64'd0);
      check("rst_addr",  64'(bus.dump_addr), 64'd0);
      check("rst_data",  64'(bus.dump_data), 64'd0);
      check("rst_rreg",  64'(bus.rf_read_reg), 64'd0);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("post_rst_busy",  64'(bus.busy), 64'd0);
      check("post_rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));

      // 2: full dump of Ri = i*0x01010101, ready always high
      for (int i = 0; i < NUM_REGS; i++) rf_write(i, DATA_W'(i) * 32'h0101_0101);
      bus.dump_ready = 1'b1;
      dc = done_cycles;
      pulse_start();
      wait_done(200, cyc);
`ifndef REGFILE_DUMP_CSUM_EN
      check("full_latency", 64'(cyc + 2), 64'd66);
`endif
      @(posedge clock); #1;
      check("full_idle_busy", 64'(bus.busy), 64'd0);
      check("full_idle_rreg", 64'(bus.rf_read_reg), 64'd0);
      check("full_done_once", 64'(done_cycles - dc), 64'd1);
      check("full_queue_empty", 64'(exp_q.size()), 64'd0);

      // 3: random contents (R0 write must be ignored), ready toggling every 3 cycles
      rf_write(0, 32'hDEAD_BEEF);
      for (int i = 1; i < NUM_REGS; i++) rf_write(i, $urandom());
      dc = done_cycles;
      bp_stop = 1'b0;
      fork
         begin
            pulse_start();
            wait_done(600, cyc);
            bp_stop = 1'b1;
         end
         begin
            ph = 0;
            while (!bp_stop) begin
               @(posedge clock); #1;
               ph++;
               if (ph == 3) begin
                  bus.dump_ready = ~bus.dump_ready;
                  ph = 0;
               end
            end
         end
      join
      bus.dump_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_done_once", 64'(done_cycles - dc), 64'd1);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // 4: start held high across the whole dump
      dc = done_cycles;
      bus.start = 1'b1;
      push_dump();
      wait_done(200, cyc);
      push_dump();
      @(posedge clock); #1;
      check("held_start_idle", 64'(bus.busy), 64'd0);
      @(posedge clock); #1;
      check("held_start_restart", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      wait_done(200, cyc);
      @(posedge clock); #1;
      check("held_done_twice", 64'(done_cycles - dc), 64'd2);
      check("held_queue_empty", 64'(exp_q.size()), 64'd0);

      // 5: reset while R12 is on the output
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (bus.dump_valid && bus.dump_addr == 6'd12) found = 1'b1;
         else begin
            @(posedge clock); #1;
         end
      end
      check("reached_r12", 64'(found), 64'd1);
      dc = done_cycles;
      #2 reset = 1'b0;
      #1;
      check("abort_busy",  64'(bus.busy), 64'd0);
      check("abort_valid", 64'(bus.dump_valid), 64'd0);
      check("abort_addr",  64'(bus.dump_addr), 64'd0);
      check("abort_data",  64'(bus.dump_data), 64'd0);
      check("abort_rreg",  64'(bus.rf_read_reg), 64'd0);
      exp_q.delete();
      @(posedge clock); #3;
      reset = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("abort_no_resume", 64'(bus.busy), 64'd0);
      check("abort_no_done", 64'(done_cycles - dc), 64'd0);
      pulse_start();
      wait_done(200, cyc);
      @(posedge clock); #1;
      check("fresh_done_once", 64'(done_cycles - dc), 64'd1);
      check("fresh_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
